// File: rtl/student_sample_ring_reader.sv
// Ring-buffer tap reader: writes each accepted sample into a circular RAM and
// then sweeps NumTaps delayed samples x[n-k] back out, one per cycle.
module student_sample_ring_reader #(
    parameter int AddrWidth = 10,
    parameter int DataSize  = 16,
    parameter int NumTaps   = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DataSize-1:0]  sample_i,
    input  logic                 sample_valid_i,
    output logic                 sample_ready_o,
    output logic                 ram_ena_o,
    output logic                 ram_wea_o,
    output logic [AddrWidth-1:0] ram_addra_o,
    output logic [DataSize-1:0]  ram_dia_o,
    output logic                 ram_enb_o,
    output logic [AddrWidth-1:0] ram_addrb_o,
    input  logic [DataSize-1:0]  ram_dob_i,
    output logic [DataSize-1:0]  tap_data_o,
    output logic [AddrWidth-1:0] tap_idx_o,
    output logic                 tap_valid_o,
    output logic                 tap_last_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    // Fill count must reach NumTaps, which can equal 2**AddrWidth.
    localparam int CntWidth = AddrWidth + 1;
    localparam logic [AddrWidth-1:0] LastTap   = AddrWidth'(NumTaps - 1);
    localparam logic [CntWidth-1:0]  FullCount = CntWidth'(NumTaps);

    state_t                 state;
    logic [AddrWidth-1:0]   wr_ptr;
    logic [AddrWidth-1:0]   tap_cnt;
    logic [CntWidth-1:0]    fill_cnt;
    logic                   ready_q;
    logic                   write_q;
    logic [AddrWidth-1:0]   addra_q;
    logic [DataSize-1:0]    dia_q;
    logic                   enb_q;
    logic [AddrWidth-1:0]   addrb_q;
    logic                   tap_valid_q;
    logic [AddrWidth-1:0]   tap_idx_q;
    logic                   tap_last_q;
    logic                   tap_keep_q;
    logic [AddrWidth-1:0]   tap_cnt_next;

    assign tap_cnt_next = tap_cnt + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            tap_cnt     <= '0;
            fill_cnt    <= '0;
            ready_q     <= 1'b0;
            write_q     <= 1'b0;
            addra_q     <= '0;
            dia_q       <= '0;
            enb_q       <= 1'b0;
            addrb_q     <= '0;
            tap_valid_q <= 1'b0;
            tap_idx_q   <= '0;
            tap_last_q  <= 1'b0;
            tap_keep_q  <= 1'b0;
        end else begin
            tap_valid_q <= 1'b0;
            tap_idx_q   <= '0;
            tap_last_q  <= 1'b0;
            tap_keep_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_valid_i && ready_q) begin
                        ready_q <= 1'b0;
                        write_q <= 1'b1;
                        addra_q <= wr_ptr;
                        dia_q   <= sample_i;
                        state   <= WRITE;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                WRITE: begin
                    write_q <= 1'b0;
                    addra_q <= '0;
                    dia_q   <= '0;
                    enb_q   <= 1'b1;
                    addrb_q <= wr_ptr;
                    tap_cnt <= '0;
                    state   <= READ;
                end
                READ: begin
                    // Tap qualifiers trail the read by one cycle to line up with RAM latency.
                    tap_valid_q <= 1'b1;
                    tap_idx_q   <= tap_cnt;
                    tap_last_q  <= (tap_cnt == LastTap);
                    tap_keep_q  <= ({1'b0, tap_cnt} <= fill_cnt);
                    if (tap_cnt == LastTap) begin
                        enb_q   <= 1'b0;
                        addrb_q <= '0;
                        tap_cnt <= '0;
                        state   <= DRAIN;
                    end else begin
                        tap_cnt <= tap_cnt_next;
                        addrb_q <= wr_ptr - tap_cnt_next;
                    end
                end
                DRAIN: begin
                    wr_ptr  <= wr_ptr + 1'b1;
                    if (fill_cnt != FullCount) begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sample_ready_o = ready_q;
    assign ram_ena_o      = write_q;
    assign ram_wea_o      = write_q;
    assign ram_addra_o    = addra_q;
    assign ram_dia_o      = dia_q;
    assign ram_enb_o      = enb_q;
    assign ram_addrb_o    = addrb_q;
    // Taps beyond the fill count point at never-written RAM and are forced to zero.
    assign tap_data_o     = (tap_valid_q && tap_keep_q) ? ram_dob_i : '0;
    assign tap_idx_o      = tap_idx_q;
    assign tap_valid_o    = tap_valid_q;
    assign tap_last_o     = tap_last_q;
    assign busy_o         = (state != IDLE);

endmodule
